// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: request arbitration, flush sequencing, stall stats.
// Optional stall watchdog compiled in with `define PIPE_STALL_WATCHDOG_EN.
module pipe_stall_ctrl #(
    parameter int unsigned MAX_STALL = 64,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             exc_req,
    input  logic [31:0]      exc_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             timeout
);

    localparam int unsigned HCW = $clog2(MAX_STALL) + 1;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        FLUSH
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       any_req;
    logic [5:0] req_pat;
    logic       force_release;

    assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

    // Oldest requesting stage wins; it freezes itself and everything upstream.
    always_comb begin
        req_pat = 6'b000000;
        priority case (1'b1)
            stallreq_mem: req_pat = 6'b011111;
            stallreq_ex:  req_pat = 6'b001111;
            stallreq_id:  req_pat = 6'b000111;
            default:      req_pat = 6'b000000;
        endcase
    end

    assign stall = (rst || state == FLUSH || force_release)
                 ? 6'b000000 : req_pat;
    assign flush = (state == FLUSH);

`ifdef PIPE_STALL_WATCHDOG_EN
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_cnt_nx;
    logic           timeout_q;

    assign force_release = !rst && state == HOLD && any_req
                         && hold_cnt == HCW'(MAX_STALL);
    assign timeout = timeout_q | force_release;

    // Count consecutive held cycles; a forced release restarts the count.
    always_comb begin
        hold_cnt_nx = '0;
        unique case (state)
            RUN: begin
                if (!exc_req && any_req)
                    hold_cnt_nx = HCW'(1);
            end
            HOLD: begin
                if (!exc_req && any_req && !force_release)
                    hold_cnt_nx = hold_cnt + HCW'(1);
            end
            default: hold_cnt_nx = '0;
        endcase
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nx;
            if (force_release)
                timeout_q <= 1'b1;
        end
    end
`else
    logic [HCW-1:0] unused_max_stall;

    assign unused_max_stall = HCW'(MAX_STALL);
    assign force_release    = 1'b0;
    assign timeout          = 1'b0;
`endif

    // Next state: exceptions preempt stalls; FLUSH always lasts one cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            RUN: begin
                if (exc_req)
                    state_nx = FLUSH;
                else if (any_req)
                    state_nx = HOLD;
            end
            HOLD: begin
                if (exc_req)
                    state_nx = FLUSH;
                else if (!any_req)
                    state_nx = RUN;
            end
            FLUSH:   state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // State register; handler address captured on the edge entering FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            new_pc <= 32'h0;
        end else begin
            state <= state_nx;
            if (state_nx == FLUSH)
                new_pc <= exc_pc;
        end
    end

    // Saturating count of cycles with the PC frozen.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall[0] && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule
